// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock divider with glitch-free run-time divisor changes.
// Optional macro CLKGEN_MULTI_SYNC_EN adds a sync_i input that phase-aligns all channels.
module clkgen_multi #(
   parameter int NCH         = 4,
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 0,
   parameter int CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [NCH-1:0]   en_i,
   input  logic             div_wr_i,
   input  logic [CH_W-1:0]  div_ch_i,
   input  logic [CNT_W-1:0] div_val_i,
`ifdef CLKGEN_MULTI_SYNC_EN
   input  logic             sync_i,
`endif
   output logic [NCH-1:0]   clk_o,
   output logic [NCH-1:0]   tick_o,
   output logic [NCH-1:0]   pend_o
);

   localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] cnt    [NCH];
   logic [CNT_W-1:0] active [NCH];
   logic [CNT_W-1:0] shadow [NCH];
   logic [NCH-1:0]   clk_q;
   logic [NCH-1:0]   tick_q;
   logic [NCH-1:0]   pend_q;
   logic [NCH-1:0]   wr_hit;
   logic             sync_now;

`ifdef CLKGEN_MULTI_SYNC_EN
   assign sync_now = sync_i;
`else
   assign sync_now = 1'b0;
`endif

   // Out-of-range channel numbers match no bit, so such writes vanish.
   always_comb begin
      wr_hit = '0;
      if (div_wr_i) begin
         for (int n = 0; n < NCH; n++) begin
            if (int'(div_ch_i) == n) wr_hit[n] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int n = 0; n < NCH; n++) begin
            cnt[n]    <= '0;
            active[n] <= DEF_DIV;
            shadow[n] <= DEF_DIV;
         end
         clk_q  <= '0;
         tick_q <= '0;
         pend_q <= '0;
      end else begin
         for (int n = 0; n < NCH; n++) begin
            if (sync_now || !en_i[n]) begin
               cnt[n]    <= '0;
               clk_q[n]  <= 1'b0;
               tick_q[n] <= 1'b0;
            end else if (cnt[n] == active[n]) begin
               cnt[n]    <= '0;
               clk_q[n]  <= ~clk_q[n];
               tick_q[n] <= ~clk_q[n];
            end else begin
               cnt[n]    <= cnt[n] + CNT_W'(1);
               tick_q[n] <= 1'b0;
            end

            // New divisors only land at a falling edge, when idle, or on sync, so no phase is ever cut short.
            if (wr_hit[n]) begin
               shadow[n] <= div_val_i;
               pend_q[n] <= 1'b1;
            end else if (pend_q[n] && (sync_now || !en_i[n] ||
                                        (cnt[n] == active[n] && clk_q[n]))) begin
               active[n] <= shadow[n];
               pend_q[n] <= 1'b0;
            end
         end
      end
   end

   assign clk_o  = clk_q;
   assign tick_o = tick_q;
   assign pend_o = pend_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// Scoreboard bench for clkgen_multi: per-cycle expected {clk,tick,pend} words are queued and compared.
module tb_clkgen_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] en;
   logic       div_wr;
   logic [1:0] div_ch;
   logic [7:0] div_val;
`ifdef CLKGEN_MULTI_SYNC_EN
   logic       sync;
`endif
   logic [2:0] clk_o;
   logic [2:0] tick_o;
   logic [2:0] pend_o;

   logic [8:0] sb[$];
   int n_checks = 0;
   int n_fail   = 0;

   clkgen_multi #(.NCH(3), .CNT_W(8), .DEFAULT_DIV(0)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .en_i(en),
      .div_wr_i(div_wr),
      .div_ch_i(div_ch),
      .div_val_i(div_val),
`ifdef CLKGEN_MULTI_SYNC_EN
      .sync_i(sync),
`endif
      .clk_o(clk_o),
      .tick_o(tick_o),
      .pend_o(pend_o)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = '0; div_wr = 1'b0; div_ch = '0; div_val = '0;
`ifdef CLKGEN_MULTI_SYNC_EN
      sync = 1'b0;
`endif
      cycle();
      cycle();
      rst = 1'b0;
   endtask

   // Loads a divisor into a disabled channel and waits for it to become active.
   task automatic preload(input int ch, input int val);
      div_wr = 1'b1; div_ch = 2'(ch); div_val = 8'(val);
      cycle();
      div_wr = 1'b0;
      cycle();
   endtask

   task automatic test_reset();
      logic [8:0] got, exp_v;
      rst = 1'b1; en = 3'b111; div_wr = 1'b1; div_ch = 2'd1; div_val = 8'd9;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin rst = 1'b0; div_wr = 1'b0; en = '0; end
         sb.push_back(9'b0);
         cycle();
         got = {clk_o, tick_o, pend_o};
         exp_v = sb.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reset k=%0d got %b exp %b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_basic();
      logic [8:0] got, exp_v;
      logic [2:0] ec, et;
      do_reset();
      en = 3'b001;
      for (int k = 1; k <= 8; k++) begin
         ec = '0; et = '0;
         ec[0] = (k % 2 == 1);
         et[0] = (k % 2 == 1);
         sb.push_back({ec, et, 3'b000});
         cycle();
         got = {clk_o, tick_o, pend_o};
         exp_v = sb.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL basic k=%0d got %b exp %b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_div_change();
      logic [8:0] got, exp_v;
      logic [2:0] ec, et, ep;
      do_reset();
      preload(1, 2);
      en = 3'b010;
      for (int k = 1; k <= 22; k++) begin
         div_wr = (k == 4); div_ch = 2'd1; div_val = 8'd4;
         ec = '0; et = '0; ep = '0;
         if (k < 6) begin
            ec[1] = ((k / 3) % 2 == 1);
            et[1] = (k % 6 == 3);
         end else begin
            ec[1] = (((k - 6) / 5) % 2 == 1);
            et[1] = ((k - 6) % 10 == 5);
         end
         ep[1] = (k == 4 || k == 5);
         sb.push_back({ec, et, ep});
         cycle();
         got = {clk_o, tick_o, pend_o};
         exp_v = sb.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL div_change k=%0d got %b exp %b", k, got, exp_v);
         end
      end
      div_wr = 1'b0;
   endtask

   task automatic test_disabled_write();
      logic [8:0] got, exp_v;
      logic [2:0] ec, et, ep;
      do_reset();
      for (int k = -1; k <= 10; k++) begin
         div_wr = (k == -1); div_ch = 2'd2; div_val = 8'd1;
         en = (k >= 1) ? 3'b100 : 3'b000;
         ec = '0; et = '0; ep = '0;
         ep[2] = (k == -1);
         if (k >= 1) begin
            ec[2] = ((k / 2) % 2 == 1);
            et[2] = (k % 4 == 2);
         end
         sb.push_back({ec, et, ep});
         cycle();
         got = {clk_o, tick_o, pend_o};
         exp_v = sb.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL disabled_write k=%0d got %b exp %b", k, got, exp_v);
         end
      end
   endtask

   task automatic test_bad_channel();
      logic [8:0] got, exp_v;
      logic [2:0] ec, et;
      do_reset();
      preload(1, 1);
      en = 3'b011;
      for (int k = 1; k <= 12; k++) begin
         div_wr = (k == 3 || k == 7); div_ch = 2'd3; div_val = (k == 3) ? 8'd5 : 8'd0;
         ec = '0; et = '0;
         ec[0] = (k % 2 == 1);
         et[0] = (k % 2 == 1);
         ec[1] = ((k / 2) % 2 == 1);
         et[1] = (k % 4 == 2);
         sb.push_back({ec, et, 3'b000});
         cycle();
         got = {clk_o, tick_o, pend_o};
         exp_v = sb.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL bad_channel k=%0d got %b exp %b", k, got, exp_v);
         end
      end
      div_wr = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [8:0] got, exp_v;
      logic [2:0] ec, et, ep;
      do_reset();
      preload(0, 3);
      en = 3'b001;
      for (int k = 1; k <= 12; k++) begin
         div_wr = (k == 5); div_ch = 2'd0; div_val = 8'd7;
         rst = (k == 6);
         ec = '0; et = '0; ep = '0;
         if (k <= 5) begin
            ec[0] = ((k / 4) % 2 == 1);
            et[0] = (k == 4);
            ep[0] = (k == 5);
         end else if (k >= 7) begin
            ec[0] = ((k - 6) % 2 == 1);
            et[0] = ((k - 6) % 2 == 1);
         end
         sb.push_back({ec, et, ep});
         cycle();
         got = {clk_o, tick_o, pend_o};
         exp_v = sb.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL reset_mid k=%0d got %b exp %b", k, got, exp_v);
         end
      end
      rst = 1'b0; div_wr = 1'b0;
   endtask

`ifdef CLKGEN_MULTI_SYNC_EN
   task automatic test_sync();
      logic [8:0] got, exp_v;
      logic [2:0] ec, et, ep;
      do_reset();
      preload(0, 1);
      preload(1, 1);
      for (int k = 1; k <= 16; k++) begin
         en = (k == 1) ? 3'b001 : 3'b011;
         sync = (k == 5);
         div_wr = (k == 5); div_ch = 2'd0; div_val = 8'd1;
         ec = '0; et = '0; ep = '0;
         if (k < 5) begin
            ec[0] = ((k / 2) % 2 == 1);
            et[0] = (k % 4 == 2);
            ec[1] = (k >= 2) && (((k - 1) / 2) % 2 == 1);
            et[1] = (k >= 2) && ((k - 1) % 4 == 2);
         end else if (k == 5) begin
            ep[0] = 1'b1;
         end else begin
            ec[0] = (((k - 5) / 2) % 2 == 1);
            et[0] = ((k - 5) % 4 == 2);
            ec[1] = ec[0];
            et[1] = et[0];
            ep[0] = ((k - 5) < 4);
         end
         sb.push_back({ec, et, ep});
         cycle();
         got = {clk_o, tick_o, pend_o};
         exp_v = sb.pop_front();
         n_checks++;
         if (got !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL sync k=%0d got %b exp %b", k, got, exp_v);
         end
      end
      sync = 1'b0; div_wr = 1'b0;
   endtask
`endif

   initial begin
      rst = 1'b1; en = '0; div_wr = 1'b0; div_ch = '0; div_val = '0;
`ifdef CLKGEN_MULTI_SYNC_EN
      sync = 1'b0;
`endif
      test_reset();
      test_basic();
      test_div_change();
      test_disabled_write();
      test_bad_channel();
      test_reset_mid();
`ifdef CLKGEN_MULTI_SYNC_EN
      test_sync();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
